// File: rtl/minirisc_seq_pkg.sv
// Shared encodings for the MiniRISC multi-cycle sequencer: FSM states,
// opcode classes and PC source selects.
package minirisc_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  localparam logic [3:0] OP_ALUR   = 4'd0;
  localparam logic [3:0] OP_ALUI   = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_JUMP   = 4'd5;
  localparam logic [3:0] OP_HALT   = 4'd15;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // Opcodes 6..14 are reserved and trap as illegal.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_JUMP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/minirisc_mem_wait_timer.sv
// Counts memory wait cycles for the current request and flags expiry on the
// last permitted wait cycle.
module minirisc_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_expired
);

  localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_cnt;

  // Expiry is qualified by an active wait, so a same-cycle ready never trips it.
  assign o_expired = i_wait && (r_cnt == LP_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_wait) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/minirisc_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MiniRISC datapath,
// with a timed handshake to a variable-latency unified memory.
module minirisc_multicycle_sequencer
  import minirisc_seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             halted,
  output logic             bus_error,
  output logic             illegal_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  logic [2:0]       r_state;
  logic             r_mem_req;
  logic             r_mem_we;
  logic             r_mem_addr_sel;
  logic             r_halted;
  logic             r_bus_error;
  logic             r_illegal_op;
  logic [CNT_W-1:0] r_instr_count;

  logic [2:0] w_next_state;
  logic       w_ir_we;
  logic       w_pc_we;
  logic [1:0] w_pc_src;
  logic       w_reg_we;
  logic       w_retire;
  logic       w_illegal;
  logic       w_timeout;
  logic       w_wait;
  logic       w_expired;

  assign w_wait = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;

  // Every state change is an entry into a new step, so it restarts the wait count.
  minirisc_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_clear   (w_next_state != r_state),
    .i_wait    (w_wait),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next_state = r_state;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = PC_SRC_INC;
    w_reg_we     = 1'b0;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          w_ir_we      = 1'b1;
          w_pc_we      = 1'b1;
          w_next_state = ST_DECODE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = ST_HALTED;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_HALT) begin
          w_retire     = 1'b1;
          w_next_state = ST_HALTED;
        end else if (!op_is_legal(opcode)) begin
          w_illegal    = 1'b1;
          w_next_state = ST_HALTED;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next_state = ST_MEM;
          OP_BRANCH: begin
            w_pc_we      = branch_taken;
            w_pc_src     = PC_SRC_BRANCH;
            w_retire     = 1'b1;
            w_next_state = ST_FETCH;
          end
          OP_JUMP: begin
            w_pc_we      = 1'b1;
            w_pc_src     = PC_SRC_JUMP;
            w_retire     = 1'b1;
            w_next_state = ST_FETCH;
          end
          default: w_next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            w_retire     = 1'b1;
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_WB;
          end
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = ST_HALTED;
        end
      end
      ST_WB: begin
        w_reg_we     = 1'b1;
        w_retire     = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_HALTED: w_next_state = ST_HALTED;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Bus controls are registered from the next state: no path from mem_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr_sel <= 1'b0;
      r_halted       <= 1'b0;
      r_bus_error    <= 1'b0;
      r_illegal_op   <= 1'b0;
      r_instr_count  <= '0;
    end else begin
      r_state        <= w_next_state;
      r_mem_req      <= (w_next_state == ST_FETCH) || (w_next_state == ST_MEM);
      r_mem_addr_sel <= (w_next_state == ST_MEM);
      r_mem_we       <= (w_next_state == ST_MEM) && (opcode == OP_STORE);
      if (w_next_state == ST_HALTED) r_halted <= 1'b1;
      if (w_timeout) r_bus_error <= 1'b1;
      if (w_illegal) r_illegal_op <= 1'b1;
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr_sel = r_mem_addr_sel;
  assign ir_we        = w_ir_we;
  assign pc_we        = w_pc_we;
  assign pc_src       = w_pc_src;
  assign reg_we       = w_reg_we;
  assign halted       = r_halted;
  assign bus_error    = r_bus_error;
  assign illegal_op   = r_illegal_op;
  assign state        = r_state;
  assign instr_count  = r_instr_count;

endmodule

// File: tb/tb_minirisc_multicycle_sequencer.sv
// Directed bench for the MiniRISC sequencer; a second instance with a 4-bit
// retire counter shares the stimulus so counter wrap is reachable quickly.
module tb_minirisc_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
  logic [1:0]  pc_src;
  logic        halted, bus_error, illegal_op;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic        s_mem_req, s_mem_we, s_mem_addr_sel, s_ir_we, s_pc_we, s_reg_we;
  logic [1:0]  s_pc_src;
  logic        s_halted, s_bus_error, s_illegal_op;
  logic [2:0]  s_state;
  logic [3:0]  s_instr_count;

  logic [10:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we}
  assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we};

  minirisc_multicycle_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) u_dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .halted(halted), .bus_error(bus_error), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count)
  );

  minirisc_multicycle_sequencer #(.CNT_W(4), .MEM_TIMEOUT(15)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr_sel(s_mem_addr_sel),
    .ir_we(s_ir_we), .pc_we(s_pc_we), .pc_src(s_pc_src), .reg_we(s_reg_we),
    .halted(s_halted), .bus_error(s_bus_error), .illegal_op(s_illegal_op),
    .state(s_state), .instr_count(s_instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; opcode = 4'd0; branch_taken = 1'b0; mem_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    n_tests++;
    if (obs !== 11'b0) begin
      $display("FAIL reset_outputs got=%b want=%b", obs, 11'b0); n_fail++;
    end
    n_tests++;
    if ({halted, bus_error, illegal_op} !== 3'b000) begin
      $display("FAIL reset_flags got=%b want=000", {halted, bus_error, illegal_op}); n_fail++;
    end
    n_tests++;
    if (instr_count !== 16'd0 || s_instr_count !== 4'd0) begin
      $display("FAIL reset_count got=%0d/%0d want=0/0", instr_count, s_instr_count); n_fail++;
    end
    do_reset();
    tick();
    n_tests++;
    if (state !== 3'd0) begin
      $display("FAIL idle_without_start got=%0d want=0", state); n_fail++;
    end
  endtask

  task automatic test_alu();
    logic [10:0] exp [5] = '{11'b001_100_11_00_0, 11'b010_000_00_00_0,
                             11'b011_000_00_00_0, 11'b101_000_00_00_1,
                             11'b001_100_11_00_0};
    do_reset();
    opcode = 4'd0; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      #1;
      n_tests++;
      if (obs !== exp[i]) begin
        $display("FAIL alu_c%0d got=%b want=%b", i + 1, obs, exp[i]); n_fail++;
      end
    end
    n_tests++;
    if (instr_count !== 16'd1) begin
      $display("FAIL alu_count got=%0d want=1", instr_count); n_fail++;
    end
  endtask

  task automatic test_load_wait();
    logic [10:0] exp [9] = '{11'b001_100_11_00_0, 11'b010_000_00_00_0,
                             11'b011_000_00_00_0, 11'b100_101_00_00_0,
                             11'b100_101_00_00_0, 11'b100_101_00_00_0,
                             11'b100_101_00_00_0, 11'b101_000_00_00_1,
                             11'b001_100_11_00_0};
    logic rdy [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    opcode = 4'd2; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      start = 1'b0;
      mem_ready = rdy[i];
      #1;
      n_tests++;
      if (obs !== exp[i]) begin
        $display("FAIL load_c%0d got=%b want=%b", i + 1, obs, exp[i]); n_fail++;
      end
    end
    n_tests++;
    if (instr_count !== 16'd1) begin
      $display("FAIL load_count got=%0d want=1", instr_count); n_fail++;
    end
  endtask

  task automatic test_store();
    logic [10:0] exp [5] = '{11'b001_100_11_00_0, 11'b010_000_00_00_0,
                             11'b011_000_00_00_0, 11'b100_111_00_00_0,
                             11'b001_100_11_00_0};
    do_reset();
    opcode = 4'd3; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      #1;
      n_tests++;
      if (obs !== exp[i]) begin
        $display("FAIL store_c%0d got=%b want=%b", i + 1, obs, exp[i]); n_fail++;
      end
    end
    n_tests++;
    if (instr_count !== 16'd1) begin
      $display("FAIL store_count got=%0d want=1", instr_count); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp [10] = '{11'b001_100_11_00_0, 11'b010_000_00_00_0,
                              11'b011_000_00_01_0, 11'b001_100_11_00_0,
                              11'b010_000_00_00_0, 11'b011_000_01_01_0,
                              11'b001_100_11_00_0, 11'b010_000_00_00_0,
                              11'b011_000_01_10_0, 11'b001_100_11_00_0};
    logic [3:0] opc [10] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5};
    logic       bt  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    opcode = 4'd4; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = 1'b0;
      opcode = opc[i];
      branch_taken = bt[i];
      #1;
      n_tests++;
      if (obs !== exp[i]) begin
        $display("FAIL bj_c%0d got=%b want=%b", i + 1, obs, exp[i]); n_fail++;
      end
      if (i == 3 || i == 6 || i == 9) begin
        n_tests++;
        if (instr_count !== 16'((i + 2) / 3)) begin
          $display("FAIL bj_count_c%0d got=%0d want=%0d", i + 1, instr_count, (i + 2) / 3);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = 4'd0; mem_ready = 1'b0; start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      start = 1'b0;
      #1;
      n_tests++;
      if (obs !== 11'b001_100_00_00_0) begin
        $display("FAIL timeout_wait%0d got=%b want=%b", i + 1, obs, 11'b001_100_00_00_0); n_fail++;
      end
    end
    tick();
    #1;
    n_tests++;
    if ({state, mem_req, bus_error, halted} !== 6'b110_0_1_1) begin
      $display("FAIL timeout_halt got=%b want=110011", {state, mem_req, bus_error, halted}); n_fail++;
    end
    start = 1'b1;
    tick(); tick(); tick();
    #1;
    n_tests++;
    if (obs !== 11'b110_000_00_00_0) begin
      $display("FAIL timeout_start_ignored got=%b want=%b", obs, 11'b110_000_00_00_0); n_fail++;
    end
    do_reset();
    opcode = 4'd0; start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      start = 1'b0;
      mem_ready = (i == 14);
      #1;
    end
    n_tests++;
    if (obs !== 11'b001_100_11_00_0) begin
      $display("FAIL ready_at_expiry got=%b want=%b", obs, 11'b001_100_11_00_0); n_fail++;
    end
    tick();
    mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({state, bus_error} !== 4'b010_0) begin
      $display("FAIL ready_at_expiry_next got=%b want=0100", {state, bus_error}); n_fail++;
    end
  endtask

  task automatic test_illegal_halt();
    do_reset();
    opcode = 4'd9; mem_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    #1;
    n_tests++;
    if (obs !== 11'b110_000_00_00_0) begin
      $display("FAIL illegal_outputs got=%b want=%b", obs, 11'b110_000_00_00_0); n_fail++;
    end
    n_tests++;
    if ({illegal_op, halted, bus_error} !== 3'b110 || instr_count !== 16'd0) begin
      $display("FAIL illegal_flags got=%b/%0d want=110/0", {illegal_op, halted, bus_error}, instr_count);
      n_fail++;
    end
    start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    #1;
    n_tests++;
    if (state !== 3'd6 || instr_count !== 16'd0) begin
      $display("FAIL illegal_absorb got=%0d/%0d want=6/0", state, instr_count); n_fail++;
    end
    do_reset();
    opcode = 4'd15; mem_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    #1;
    n_tests++;
    if ({state, halted, illegal_op} !== 5'b110_1_0 || instr_count !== 16'd1) begin
      $display("FAIL halt_flags got=%b/%0d want=11010/1", {state, halted, illegal_op}, instr_count);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = 4'd2; mem_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick(); mem_ready = 1'b0;
    tick();
    #1;
    n_tests++;
    if ({state, mem_req, mem_addr_sel} !== 5'b100_1_1) begin
      $display("FAIL mid_mem_pre got=%b want=10011", {state, mem_req, mem_addr_sel}); n_fail++;
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({state, mem_req, mem_addr_sel} !== 5'b000_0_0) begin
      $display("FAIL mid_mem_async got=%b want=00000", {state, mem_req, mem_addr_sel}); n_fail++;
    end
    mem_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    #1;
    n_tests++;
    if ({state, mem_req, reg_we} !== 5'b000_0_0 || instr_count !== 16'd0) begin
      $display("FAIL mid_mem_ignored got=%b/%0d want=00000/0", {state, mem_req, reg_we}, instr_count);
      n_fail++;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_count_wrap();
    do_reset();
    opcode = 4'd5; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 46; i++) begin
      tick();
      start = 1'b0;
    end
    #1;
    n_tests++;
    if (instr_count !== 16'd15 || s_instr_count !== 4'hF) begin
      $display("FAIL wrap_pre got=%0d/%0d want=15/15", instr_count, s_instr_count); n_fail++;
    end
    tick(); tick(); tick();
    #1;
    n_tests++;
    if (instr_count !== 16'd16 || s_instr_count !== 4'h0 || s_state !== 3'd1) begin
      $display("FAIL wrap_post got=%0d/%0d/%0d want=16/0/1", instr_count, s_instr_count, s_state);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_timeout();
    test_illegal_halt();
    test_reset_mid_mem();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
